fifo_ctrl: RTL

Synchronous FIFO controller that sits directly upstream of the `dual_ram` storage block. It turns a simple push/pop request interface into the `write`/`read` strobes and the `wr_addr`/`rd_addr` addresses that `dual_ram` consumes. It maintains the full/empty/occupancy state and a read-data-valid strobe aligned to `dual_ram`'s registered `data_out`. No data passes through this block: push data goes straight to `dual_ram.data_in`, and pop data is taken from `dual_ram.data_out`.

---
 rtl/fifo_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller in front of a dual_ram storage block.
// Converts push/pop requests into dual_ram write/read strobes and addresses,
// and tracks full/empty/occupancy plus a read-data-valid strobe aligned to
// dual_ram's registered data_out. No data passes through this block.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN adds err_clr/overflow/underflow.
//
// Ports:
//   clk       rising-edge clock shared with dual_ram
//   reset     synchronous active-low reset
//   push      write request (data presented directly to dual_ram.data_in)
//   pop       read request
//   write     dual_ram write strobe, push & ~full (0 during reset)
//   read      dual_ram read strobe, pop & ~empty (0 during reset)
//   wr_addr   dual_ram write address (low bits of write pointer)
//   rd_addr   dual_ram read address (low bits of read pointer)
//   full      DEPTH entries held
//   empty     no entries held
//   count     occupancy 0..DEPTH
//   rd_valid  dual_ram.data_out carries popped data this cycle
//   err_clr   clears sticky error flags           (FIFO_ERR_FLAGS_EN)
//   overflow  sticky: a push was rejected          (FIFO_ERR_FLAGS_EN)
//   underflow sticky: a pop was rejected           (FIFO_ERR_FLAGS_EN)

module fifo_ctrl #(
    parameter int unsigned ADDR  = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    output logic            write,
    output logic            read,
    output logic [ADDR-1:0] wr_addr,
    output logic [ADDR-1:0] rd_addr,
    output logic            full,
    output logic            empty,
    output logic [ADDR:0]   count,
    output logic            rd_valid
`ifdef FIFO_ERR_FLAGS_EN
    ,
    input  logic            err_clr,
    output logic            overflow,
    output logic            underflow
`endif
);

    localparam int unsigned PW = ADDR + 1;

    // Only power-of-two depths matching the address width are supported.
    generate
        if (DEPTH != (1 << ADDR)) begin : g_bad_depth
            $error("fifo_ctrl: DEPTH must equal 2**ADDR");
        end
    endgenerate

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Flags derive only from registered pointers; the MSB is the wrap bit.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr == {~rd_ptr[ADDR], rd_ptr[ADDR-1:0]});
        count   = wr_ptr - rd_ptr;
        wr_addr = wr_ptr[ADDR-1:0];
        rd_addr = rd_ptr[ADDR-1:0];
    end

    // Strobes are suppressed while reset is held so dual_ram sees no access.
    always_comb begin
        write = reset & push & ~full;
        read  = reset & pop & ~empty;
    end

    // Pointer advance and read-valid pipeline stage matching dual_ram latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (write) wr_ptr <= wr_ptr + PW'(1);
            if (read)  rd_ptr <= rd_ptr + PW'(1);
            rd_valid <= read;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags; a new rejection beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full)  overflow <= 1'b1;
            else if (err_clr)  overflow <= 1'b0;
            if (pop && empty)  underflow <= 1'b1;
            else if (err_clr)  underflow <= 1'b0;
        end
    end
`endif

endmodule
